// File: rtl/dc_settle_pkg.sv
// dc_settle_pkg: shared types and constants for the DC-reject settle controller.
// Holds the FSM state enum, the stage-index width and the Q1.x fixed-point helpers.
package dc_settle_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    SETTLE,
    TRACK
  } state_t;

  function automatic logic [63:0] one_of(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] leak_max_of(input int w);
    return 64'd1 << (w - 2);
  endfunction

endpackage

// File: rtl/dc_leak_sched.sv
// dc_leak_sched: maps (stage, tracking alpha) to the fast-settle alpha.
// The leak is widened before shifting so the clamp sees the true magnitude.
module dc_leak_sched
  import dc_settle_pkg::*;
#(
  parameter int ALPHA_W    = 24,
  parameter int NUM_STAGES = 3,
  parameter int SHIFT_STEP = 2
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [ALPHA_W-1:0] alpha_final,
  output logic [ALPHA_W-1:0] alpha_s
);

  localparam int WW = ALPHA_W + SHIFT_STEP * NUM_STAGES;
  localparam logic [ALPHA_W-1:0] ONE =
    ALPHA_W'(one_of(ALPHA_W));
  localparam logic [ALPHA_W-1:0] LMAX =
    ALPHA_W'(leak_max_of(ALPHA_W));

  logic [ALPHA_W-1:0] d;
  logic [ALPHA_W-1:0] leak;
  logic [WW-1:0]      wide;
  int                 sh;

  // leak = d << shift, clamped to half scale, never below the tracking leak
  always_comb begin
    d = (alpha_final >= ONE) ? '0 : ONE - alpha_final;
    sh = 0;
    if (int'(stage) < NUM_STAGES)
      sh = SHIFT_STEP * (NUM_STAGES - int'(stage));
    wide = WW'(d) << sh;
    if (d >= LMAX)
      leak = d;
    else if (wide > WW'(LMAX))
      leak = LMAX;
    else
      leak = wide[ALPHA_W-1:0];
    alpha_s = ONE - leak;
  end

endmodule

// File: rtl/dc_settle_ctrl.sv
// dc_settle_ctrl: flush / fast-settle / track sequencer for the DC-reject pole.
// Define DC_SETTLE_AUTOSTART_EN to start a flush automatically after reset.
module dc_settle_ctrl
  import dc_settle_pkg::*;
#(
  parameter int ALPHA_W      = 24,
  parameter int NUM_STAGES   = 3,
  parameter int SHIFT_STEP   = 2,
  parameter int STAGE_LEN    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ALPHA_W-1:0] alpha_final,
  input  logic               in_valid,
  output logic               filt_reset,
  output logic [ALPHA_W-1:0] alpha,
  output logic               out_gate,
  output logic               settled,
  output logic [STAGE_W-1:0] stage
);

  localparam int CNT_W = $clog2(STAGE_LEN + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

  state_t             state, state_n;
  logic [FL_W-1:0]    fcnt, fcnt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [STAGE_W-1:0] stg_n;
  logic [ALPHA_W-1:0] alpha_s;
  logic               go;

`ifdef DC_SETTLE_AUTOSTART_EN
  logic auto_q;

  // one-shot start in the first cycle after reset releases
  always_ff @(posedge clk) begin
    auto_q <= reset;
  end

  assign go = start | auto_q;
`else
  assign go = start;
`endif

  dc_leak_sched #(
    .ALPHA_W   (ALPHA_W),
    .NUM_STAGES(NUM_STAGES),
    .SHIFT_STEP(SHIFT_STEP)
  ) u_sched (
    .stage      (stg_n),
    .alpha_final(alpha_final),
    .alpha_s    (alpha_s)
  );

  // next state, flush count, sample count and stage index
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    cnt_n   = cnt;
    stg_n   = stage;
    unique case (state)
      IDLE: ;
      FLUSH: begin
        if (fcnt == FL_W'(FLUSH_CYCLES - 1)) begin
          state_n = SETTLE;
          stg_n   = '0;
          cnt_n   = '0;
        end else begin
          fcnt_n = fcnt + FL_W'(1);
        end
      end
      SETTLE: begin
        if (in_valid) begin
          if (cnt == CNT_W'(STAGE_LEN - 1)) begin
            cnt_n = '0;
            if (stage == STAGE_W'(NUM_STAGES - 1)) begin
              state_n = TRACK;
              stg_n   = '0;
            end else begin
              stg_n = stage + STAGE_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      TRACK: ;
    endcase
    if (go) begin
      state_n = FLUSH;
      fcnt_n  = '0;
      cnt_n   = '0;
      stg_n   = '0;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fcnt       <= '0;
      cnt        <= '0;
      stage      <= '0;
      filt_reset <= 1'b1;
      alpha      <= alpha_final;
      out_gate   <= 1'b0;
      settled    <= 1'b0;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      cnt        <= cnt_n;
      stage      <= stg_n;
      filt_reset <= (state_n == FLUSH);
      alpha      <= (state_n == SETTLE) ? alpha_s : alpha_final;
      out_gate   <= (state_n == TRACK);
      settled    <= (state_n == TRACK);
    end
  end

endmodule
